host_reg_if: RTL and testbench

//  CPU register-bus slave: the MAC-side stage that consumes host accesses (CSB/WRB/CA/CD_in) and returns CD_out.

---
 rtl/host_reg_if_pkg.sv | 23 ++
 rtl/host_sync2.sv | 21 ++
 rtl/host_reg_if.sv | 159 +++++++++++++++
 tb/tb_host_reg_if.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/host_reg_if_pkg.sv
// Shared word addresses and FSM encoding for the host register slave.
// Imported by the RTL and by the bench.
package host_reg_if_pkg;

    localparam logic [6:0] ADDR_CTRL       = 7'h00;
    localparam logic [6:0] ADDR_MAC_L      = 7'h01;
    localparam logic [6:0] ADDR_MAC_M      = 7'h02;
    localparam logic [6:0] ADDR_MAC_H      = 7'h03;
    localparam logic [6:0] ADDR_TX_IFG     = 7'h04;
    localparam logic [6:0] ADDR_INT_STATUS = 7'h05;
    localparam logic [6:0] ADDR_INT_MASK   = 7'h06;
    localparam logic [6:0] ADDR_SCRATCH    = 7'h07;
    localparam logic [6:0] ADDR_VERSION    = 7'h08;
    localparam logic [6:0] ADDR_WR_COUNT   = 7'h09;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CAPT     = 2'd1,
        ST_COMMIT   = 2'd2,
        ST_WAIT_REL = 2'd3
    } state_t;

endpackage

// File: rtl/host_sync2.sv
// Two-flop synchroniser; reset loads the inactive (high) level.
module host_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic s1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1 <= 1'b1;
            q  <= 1'b1;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/host_reg_if.sv
// Host register-bus slave: CSB sync, capture/commit FSM, 10-entry register file.
// HOST_REG_RDCLR_EN: a read of INT_STATUS also clears it.
module host_reg_if
    import host_reg_if_pkg::*;
#(
    parameter logic [47:0] MAC_ADDR_RST = 48'h0000_0000_0000,
    parameter logic [15:0] VERSION      = 16'h0100,
    parameter logic [7:0]  IFG_RST      = 8'd12
) (
    input  logic        Clk_reg,
    input  logic        Reset,
    input  logic        CSB,
    input  logic        WRB,
    input  logic [7:0]  CA,
    input  logic [15:0] CD_in,
    output logic [15:0] CD_out,
    output logic [15:0] ctrl,
    output logic [47:0] mac_addr,
    output logic [7:0]  tx_ifg,
    input  logic [7:0]  int_src,
    output logic        int_o,
    output logic        access_done
);

    state_t      state_q, state_d;
    logic        cs_s2;
    logic [1:0]  live_sr;
    logic        capt_en, commit_en;
    logic [6:0]  addr_q;
    logic        rd_q;
    logic [15:0] wdata_q;
    logic        wr_en, rd_en;
    logic [15:0] mac_l, mac_m, mac_h;
    logic [7:0]  int_status, int_mask, int_clr;
    logic [15:0] scratch, wr_count, rdata;
    logic        unused_ca0;

    assign unused_ca0 = CA[0];

    host_sync2 u_sync (
        .clk   (Clk_reg),
        .rst_n (Reset),
        .d     (CSB),
        .q     (cs_s2)
    );

    // cs_s2 only reflects the pin two edges after reset release
    always_ff @(posedge Clk_reg) begin
        if (!Reset) live_sr <= 2'b00;
        else        live_sr <= {live_sr[0], 1'b1};
    end

    always_ff @(posedge Clk_reg) begin
        if (!Reset) state_q <= ST_WAIT_REL;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (!cs_s2) state_d = ST_CAPT;
            ST_CAPT:     state_d = ST_COMMIT;
            ST_COMMIT:   state_d = ST_WAIT_REL;
            ST_WAIT_REL: if (cs_s2 && live_sr[1]) state_d = ST_IDLE;
            default:     state_d = ST_WAIT_REL;
        endcase
    end

    always_comb begin
        capt_en     = (state_q == ST_IDLE) && !cs_s2;
        commit_en   = (state_q == ST_CAPT);
        access_done = (state_q == ST_COMMIT);
    end

    always_ff @(posedge Clk_reg) begin
        if (!Reset) begin
            addr_q  <= '0;
            rd_q    <= 1'b1;
            wdata_q <= '0;
        end else if (capt_en) begin
            addr_q  <= CA[7:1];
            rd_q    <= WRB;
            wdata_q <= CD_in;
        end
    end

    assign wr_en = commit_en && !rd_q;
    assign rd_en = commit_en && rd_q;

    always_comb begin
        rdata = 16'h0000;
        case (addr_q)
            ADDR_CTRL:       rdata = ctrl;
            ADDR_MAC_L:      rdata = mac_l;
            ADDR_MAC_M:      rdata = mac_m;
            ADDR_MAC_H:      rdata = mac_h;
            ADDR_TX_IFG:     rdata = {8'h00, tx_ifg};
            ADDR_INT_STATUS: rdata = {8'h00, int_status};
            ADDR_INT_MASK:   rdata = {8'h00, int_mask};
            ADDR_SCRATCH:    rdata = scratch;
            ADDR_VERSION:    rdata = VERSION;
            ADDR_WR_COUNT:   rdata = wr_count;
            default:         rdata = 16'h0000;
        endcase
    end

    always_comb begin
        int_clr = 8'h00;
        if (wr_en && addr_q == ADDR_INT_STATUS) int_clr = wdata_q[7:0];
`ifdef HOST_REG_RDCLR_EN
        if (rd_en && addr_q == ADDR_INT_STATUS) int_clr = 8'hFF;
`else
`endif
    end

    always_ff @(posedge Clk_reg) begin
        if (!Reset) begin
            ctrl     <= 16'h0000;
            mac_l    <= MAC_ADDR_RST[15:0];
            mac_m    <= MAC_ADDR_RST[31:16];
            mac_h    <= MAC_ADDR_RST[47:32];
            tx_ifg   <= IFG_RST;
            int_mask <= 8'h00;
            scratch  <= 16'h0000;
            wr_count <= 16'h0000;
        end else if (wr_en) begin
            wr_count <= wr_count + 16'd1;
            case (addr_q)
                ADDR_CTRL:     ctrl     <= wdata_q;
                ADDR_MAC_L:    mac_l    <= wdata_q;
                ADDR_MAC_M:    mac_m    <= wdata_q;
                ADDR_MAC_H:    mac_h    <= wdata_q;
                ADDR_TX_IFG:   tx_ifg   <= wdata_q[7:0];
                ADDR_INT_MASK: int_mask <= wdata_q[7:0];
                ADDR_SCRATCH:  scratch  <= wdata_q;
                default:       ;
            endcase
        end
    end

    // new events override a same-cycle clear
    always_ff @(posedge Clk_reg) begin
        if (!Reset) begin
            int_status <= 8'h00;
            int_o      <= 1'b0;
        end else begin
            int_status <= (int_status & ~int_clr) | int_src;
            int_o      <= |(int_status & int_mask);
        end
    end

    always_ff @(posedge Clk_reg) begin
        if (!Reset)     CD_out <= 16'h0000;
        else if (rd_en) CD_out <= rdata;
    end

    assign mac_addr = {mac_h, mac_m, mac_l};

endmodule

// File: tb/tb_host_reg_if.sv
// Directed bench for host_reg_if with a read-data scoreboard queue.
module tb_host_reg_if;
    import host_reg_if_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        csb;
    logic        wrb;
    logic [7:0]  ca;
    logic [15:0] cd_in;
    logic [15:0] cd_out;
    logic [15:0] ctrl;
    logic [47:0] mac_addr;
    logic [7:0]  tx_ifg;
    logic [7:0]  int_src;
    logic        int_o;
    logic        access_done;

    int          tests = 0;
    int          fails = 0;
    int          wcount = 0;
    logic [15:0] sb[$];

    always #5 clk = ~clk;

    host_reg_if dut (
        .Clk_reg     (clk),
        .Reset       (rst_n),
        .CSB         (csb),
        .WRB         (wrb),
        .CA          (ca),
        .CD_in       (cd_in),
        .CD_out      (cd_out),
        .ctrl        (ctrl),
        .mac_addr    (mac_addr),
        .tx_ifg      (tx_ifg),
        .int_src     (int_src),
        .int_o       (int_o),
        .access_done (access_done)
    );

    task automatic chk(input string tag, input logic [47:0] obs,
                       input logic [47:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // pulse: int_src value driven so it is sampled on the commit edge
    task automatic acc(input bit wr, input logic [6:0] a,
                       input logic [15:0] d, input int hold,
                       input logic [7:0] pulse);
        int pulses = 0;
        logic [15:0] e;
        csb = 1'b0;
        wrb = !wr;
        ca = {a, 1'b1};
        cd_in = d;
        for (int i = 0; i < hold + 4; i++) begin
            @(negedge clk);
            int_src = (i == 2) ? pulse : 8'h00;
            if (access_done) begin
                pulses++;
                if (!wr && sb.size() > 0) begin
                    e = sb.pop_front();
                    chk($sformatf("rd_%0h", a), {32'h0, cd_out}, {32'h0, e});
                end
            end
            if (i == hold - 1) csb = 1'b1;
        end
        chk($sformatf("done_%0h", a), pulses, 1);
        if (!wr && pulses == 0 && sb.size() > 0) void'(sb.pop_front());
        if (wr) wcount++;
    endtask

    task automatic wr(input logic [6:0] a, input logic [15:0] d);
        acc(1'b1, a, d, 4, 8'h00);
    endtask

    task automatic rd(input logic [6:0] a, input logic [15:0] e);
        sb.push_back(e);
        acc(1'b0, a, 16'h0, 4, 8'h00);
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        csb = 1'b1;
        wrb = 1'b1;
        ca = 8'h00;
        cd_in = 16'h0;
        int_src = 8'h00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_cd_out", cd_out, 0);
        chk("rst_int_o", int_o, 0);
        chk("rst_done", access_done, 0);
        chk("rst_ctrl", ctrl, 0);
        chk("rst_ifg", tx_ifg, 8'd12);
        repeat (3) @(negedge clk);

        rd(ADDR_VERSION, 16'h0100);
        rd(ADDR_TX_IFG, 16'h000C);
        rd(ADDR_MAC_L, 16'h0000);

        wr(ADDR_SCRATCH, 16'hA5A5);
        rd(ADDR_SCRATCH, 16'hA5A5);
        rd(ADDR_WR_COUNT, 16'h0001);
        chk("cd_hold", cd_out, 16'h0001);

        wr(ADDR_TX_IFG, 16'hFF20);
        chk("ifg_out", tx_ifg, 8'h20);
        rd(ADDR_TX_IFG, 16'h0020);
        wr(ADDR_MAC_L, 16'h3344);
        wr(ADDR_MAC_M, 16'h1122);
        wr(ADDR_MAC_H, 16'hABCD);
        chk("mac_addr", mac_addr, 48'hABCD_1122_3344);
        wr(ADDR_CTRL, 16'h1234);
        chk("ctrl", ctrl, 16'h1234);
        wr(ADDR_VERSION, 16'hFFFF);
        rd(ADDR_VERSION, 16'h0100);
        wr(ADDR_WR_COUNT, 16'hFFFF);
        rd(ADDR_WR_COUNT, 16'(wcount));

        wr(ADDR_INT_MASK, 16'hFF03);
        rd(ADDR_INT_MASK, 16'h0003);
        @(negedge clk);
        int_src = 8'h01;
        @(negedge clk);
        int_src = 8'h00;
        chk("int_o_lag", int_o, 0);
        @(negedge clk);
        chk("int_o_set", int_o, 1);
        rd(ADDR_INT_STATUS, 16'h0001);
        wr(ADDR_INT_STATUS, 16'h0001);
        chk("int_o_clr", int_o, 0);
        rd(ADDR_INT_STATUS, 16'h0000);

        acc(1'b1, ADDR_INT_STATUS, 16'h0001, 4, 8'h01);
        chk("set_wins_int_o", int_o, 1);
        rd(ADDR_INT_STATUS, 16'h0001);
`ifdef HOST_REG_RDCLR_EN
        rd(ADDR_INT_STATUS, 16'h0000);
`else
        rd(ADDR_INT_STATUS, 16'h0001);
`endif
        wr(ADDR_INT_STATUS, 16'h00FF);
        rd(ADDR_INT_STATUS, 16'h0000);
        chk("int_o_final", int_o, 0);

        acc(1'b1, ADDR_SCRATCH, 16'h5A5A, 20, 8'h00);
        rd(ADDR_SCRATCH, 16'h5A5A);
        rd(ADDR_WR_COUNT, 16'(wcount));

        for (int i = 0; i < 3; i++) wr(7'h7F, 16'(16'hBEEF + i));
        rd(7'h7F, 16'h0000);
        rd(ADDR_WR_COUNT, 16'(wcount));
        chk("ctrl_kept", ctrl, 16'h1234);

        csb = 1'b0;
        wrb = 1'b0;
        ca = {ADDR_CTRL, 1'b0};
        cd_in = 16'h7777;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        repeat (12) begin
            @(negedge clk);
            if (access_done) n++;
        end
        chk("no_acc_after_rst", n, 0);
        chk("rst2_ctrl", ctrl, 0);
        csb = 1'b1;
        repeat (4) @(negedge clk);
        wcount = 0;
        rd(ADDR_WR_COUNT, 16'h0000);
        rd(ADDR_VERSION, 16'h0100);
        chk("sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
